// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and stage-offset helpers for the pipelined adder/subtractor
package arith_pkg;

  localparam int ADD_DATA_WIDTH = 64;
  localparam int ADD_STG_WIDTH  = 16;

  function automatic int num_stg(input int dw, input int sw);
    return dw / sw;
  endfunction

  // Stage k forwards the (dw - (k+1)*sw) operand bits above its own slice;
  // stages are packed back to back, so this is the start bit of stage k.
  function automatic int fwd_off(input int dw, input int sw, input int k);
    return k * dw - (sw * k * (k + 1)) / 2;
  endfunction

  // Stage k holds (k+1)*sw finished difference bits, packed back to back.
  function automatic int dif_off(input int sw, input int k);
    return (sw * k * (k + 1)) / 2;
  endfunction

endpackage

// File: rtl/sub_64bit_if.sv
// rtl/sub_64bit_if.sv - operand/result bundle of the pipelined subtractor
interface sub_64bit_if #(
  parameter int DATA_WIDTH = 64
);

  logic                  i_en;
  logic [DATA_WIDTH-1:0] adda;
  logic [DATA_WIDTH-1:0] addb;
  logic [DATA_WIDTH:0]   result;
  logic                  o_en;

  modport master (output i_en, adda, addb, input result, o_en);
  modport slave  (input i_en, adda, addb, output result, o_en);

endinterface

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational single-slice subtract with borrow in/out
module sub_slice #(
  parameter int STG_WITCH = 16
) (
  input  logic [STG_WITCH-1:0] a,
  input  logic [STG_WITCH-1:0] b,
  input  logic                 bin,
  output logic [STG_WITCH-1:0] d,
  output logic                 bout
);

  logic [STG_WITCH:0] w_full;

  // One extra bit catches the borrow: a negative result wraps into the top bit.
  assign w_full = {1'b0, a} - {1'b0, b} - {{STG_WITCH{1'b0}}, bin};
  assign d      = w_full[STG_WITCH-1:0];
  assign bout   = w_full[STG_WITCH];

endmodule

// File: rtl/sub_64bit.sv
// rtl/sub_64bit.sv - pipelined wide subtractor, one slice per stage, registered borrow ripple
module sub_64bit
  import arith_pkg::*;
#(
  parameter int DATA_WIDTH = ADD_DATA_WIDTH,
  parameter int STG_WITCH  = ADD_STG_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_64bit_if.slave  bus
);

  localparam int NUM_STG = num_stg(DATA_WIDTH, STG_WITCH);
  localparam int W       = STG_WITCH;
  localparam int A_TOT   = fwd_off(DATA_WIDTH, W, NUM_STG - 1);
  localparam int A_W     = (A_TOT > 0) ? A_TOT : 1;
  localparam int D_TOT   = dif_off(W, NUM_STG);

  if (DATA_WIDTH % STG_WITCH != 0) begin : g_width_chk
    $error("sub_64bit: DATA_WIDTH must be a multiple of STG_WITCH");
  end

  // Triangular skew/deskew storage: operand remainders shrink, finished differences grow.
  logic [A_W-1:0]     r_a, r_b, w_a_nxt, w_b_nxt;
  logic [D_TOT-1:0]   r_d, w_d_nxt;
  logic [NUM_STG-1:0] r_bor, w_bor_nxt, r_en;

  for (genvar k = 0; k < NUM_STG; k++) begin : g_stg
    localparam int IN_W = DATA_WIDTH - k * W;

    logic [IN_W-1:0] w_ain;
    logic [IN_W-1:0] w_bin_op;
    logic            w_bin;
    logic [W-1:0]    w_d;

    if (k == 0) begin : g_head
      assign w_ain           = bus.adda;
      assign w_bin_op        = bus.addb;
      assign w_bin           = 1'b0;
      assign w_d_nxt[W-1:0]  = w_d;
    end else begin : g_body
      localparam int AO_IN   = fwd_off(DATA_WIDTH, W, k - 1);
      localparam int DO_PREV = dif_off(W, k - 1);
      localparam int DO      = dif_off(W, k);
      assign w_ain                      = r_a[AO_IN +: IN_W];
      assign w_bin_op                   = r_b[AO_IN +: IN_W];
      assign w_bin                      = r_bor[k-1];
      assign w_d_nxt[DO +: (k + 1) * W] = {w_d, r_d[DO_PREV +: k * W]};
    end

    if (k < NUM_STG - 1) begin : g_fwd
      localparam int AO = fwd_off(DATA_WIDTH, W, k);
      assign w_a_nxt[AO +: IN_W - W] = w_ain[IN_W-1:W];
      assign w_b_nxt[AO +: IN_W - W] = w_bin_op[IN_W-1:W];
    end

    sub_slice #(.STG_WITCH(W)) u_slice (
      .a    (w_ain[W-1:0]),
      .b    (w_bin_op[W-1:0]),
      .bin  (w_bin),
      .d    (w_d),
      .bout (w_bor_nxt[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_d   <= '0;
      r_bor <= '0;
      r_en  <= '0;
    end else begin
      r_a   <= w_a_nxt;
      r_b   <= w_b_nxt;
      r_d   <= w_d_nxt;
      r_bor <= w_bor_nxt;
      r_en  <= (r_en << 1) | NUM_STG'(bus.i_en);
    end
  end

  assign bus.result = {r_bor[NUM_STG-1], r_d[D_TOT-1 -: DATA_WIDTH]};
  assign bus.o_en   = r_en[NUM_STG-1];

endmodule

// File: tb/tb_sub_64bit.sv
// tb/tb_sub_64bit.sv - directed and random checks of sub_64bit against a delayed golden difference
module tb_sub_64bit;

  localparam int DW  = 64;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;

  int n_assert = 0;
  int n_fail   = 0;

  logic          m_en  [LAT];
  logic          m_chk [LAT];
  logic [DW:0]   m_res [LAT];

  sub_64bit_if #(.DATA_WIDTH(DW)) bus ();

  sub_64bit #(.DATA_WIDTH(DW), .STG_WITCH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW:0] gold(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW:0] exp, input logic known);
    rst_n     = rst;
    bus.i_en  = en;
    bus.adda  = a;
    bus.addb  = b;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        m_en[i]  = 1'b0;
        m_chk[i] = 1'b1;
        m_res[i] = '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        m_en[i]  = m_en[i-1];
        m_chk[i] = m_chk[i-1];
        m_res[i] = m_res[i-1];
      end
      m_en[0]  = en;
      m_chk[0] = en | known;
      m_res[0] = exp;
    end
    #1;
    n_assert++;
    assert (bus.o_en === m_en[LAT-1]) else begin
      n_fail++;
      $error("FAIL %s o_en: got %0b expected %0b", tag, bus.o_en, m_en[LAT-1]);
    end
    if (m_chk[LAT-1]) begin
      n_assert++;
      assert (bus.result === m_res[LAT-1]) else begin
        n_fail++;
        $error("FAIL %s result: got %h expected %h", tag, bus.result, m_res[LAT-1]);
      end
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] a, b;
    logic          en;

    for (int i = 0; i < LAT; i++) begin
      m_en[i]  = 1'b0;
      m_chk[i] = 1'b0;
      m_res[i] = '0;
    end
    rst_n    = 1'b0;
    bus.i_en = 1'b0;
    bus.adda = '0;
    bus.addb = '0;

    // Reset held with live operands, then quiet cycles after release.
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      step("reset_hold", 1'b0, 1'b1, a, b, '0, 1'b1);
    end
    for (int i = 0; i < LAT; i++) step("reset_release", 1'b1, 1'b0, '0, '0, '0, 1'b1);

    // Single pulse latency.
    step("latency", 1'b1, 1'b1, 64'h10, 64'h3, 65'h0_0000_0000_0000_000D, 1'b0);
    idle("latency_drain", 6);

    // Borrow ripple and extreme operands, back to back.
    step("ripple_0_minus_1", 1'b1, 1'b1, 64'h0, 64'h1, 65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
    step("ripple_top_slice", 1'b1, 1'b1, 64'h0001_0000_0000_0000, 64'h1,
         65'h0_0000_FFFF_FFFF_FFFF, 1'b0);
    step("equal_ones", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h0, 1'b0);
    step("ones_minus_0", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
         65'h0_FFFF_FFFF_FFFF_FFFF, 1'b0);
    step("equal_mid", 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 65'h0, 1'b0);
    step("small_minus_big", 1'b1, 1'b1, 64'h5, 64'h8000_0000_0000_0000,
         65'h1_8000_0000_0000_0005, 1'b0);
    idle("directed_drain", LAT);

    // Back-to-back random stream.
    for (int i = 0; i < 500; i++) begin
      a = 64'($random) * 64'($random);
      b = 64'($random) * 64'($random);
      step("back_to_back", 1'b1, 1'b1, a, b, gold(a, b), 1'b0);
    end
    idle("b2b_drain", LAT);

    // Gapped stream with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      en = 1'($urandom_range(0, 1));
      if (i == 20) step("mid_reset", 1'b0, 1'b1, a, b, '0, 1'b1);
      else         step("gapped", 1'b1, en, a, b, gold(a, b), 1'b0);
    end
    idle("gapped_drain", LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
